// File: rtl/image_decimator.sv
`default_nettype none
// ============================================================================
// Module   : image_decimator
// Brief    : Raster downscaler, 2^X_SHIFT horizontal (pick or box-average)
//            by 2^Y_SHIFT vertical (row keep) with line/frame markers.
// Revision : 1.0
// ============================================================================
module image_decimator #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 10,
    parameter int CH         = 3,
    parameter int X_SHIFT    = 1,
    parameter int Y_SHIFT    = 1
) (
    input  logic                 iclk,
    input  logic                 irst,
    input  logic                 iDVAL,
    input  logic                 iSOF,
    input  logic [CH*DATA_W-1:0] iData,
    input  logic                 iAvg,
    output logic                 oDVAL,
    output logic [CH*DATA_W-1:0] oData,
    output logic                 oEOL,
    output logic                 oEOF
);

    localparam int c_XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int c_AW = DATA_W + X_SHIFT;

    localparam logic [c_XW-1:0] c_X_MASK = c_XW'((1 << X_SHIFT) - 1);
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_WIDTH - 1);
    localparam logic [c_XW-1:0] c_X_EOL  = c_XW'(IMG_WIDTH - (1 << X_SHIFT));
    localparam logic [c_YW-1:0] c_Y_MASK = c_YW'((1 << Y_SHIFT) - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_HEIGHT - 1);
    localparam logic [c_YW-1:0] c_Y_EOF  = c_YW'(IMG_HEIGHT - (1 << Y_SHIFT));

    generate
        if ((IMG_WIDTH % (1 << X_SHIFT)) != 0) begin : g_bad_width
            $error("image_decimator: IMG_WIDTH not a multiple of 2**X_SHIFT");
        end
        if ((IMG_HEIGHT % (1 << Y_SHIFT)) != 0) begin : g_bad_height
            $error("image_decimator: IMG_HEIGHT not a multiple of 2**Y_SHIFT");
        end
    endgenerate

    logic [c_XW-1:0]      r_x_cnt;
    logic [c_YW-1:0]      r_y_cnt;
    logic                 r_mode;

    logic [c_XW-1:0]      w_x;
    logic [c_YW-1:0]      w_y;
    logic                 w_origin;
    logic                 w_mode;
    logic                 w_keep;
    logic                 w_first;
    logic                 w_last;
    logic                 w_emit;
    logic                 w_eol;
    logic                 w_eof;
    logic [CH*DATA_W-1:0] w_avg;
    logic [CH*DATA_W-1:0] w_out;

    // A start-of-frame pixel overrides the counters and is treated as x=0,y=0.
    assign w_x      = iSOF ? '0 : r_x_cnt;
    assign w_y      = iSOF ? '0 : r_y_cnt;
    assign w_origin = (w_x == '0) && (w_y == '0);
    assign w_mode   = w_origin ? iAvg : r_mode;
    assign w_keep   = (w_y & c_Y_MASK) == '0;
    assign w_first  = (w_x & c_X_MASK) == '0;
    assign w_last   = (w_x & c_X_MASK) == c_X_MASK;
    assign w_emit   = iDVAL && w_keep && (w_mode ? w_last : w_first);
    assign w_eol    = w_x >= c_X_EOL;
    assign w_eof    = w_eol && (w_y == c_Y_EOF);
    assign w_out    = w_mode ? w_avg : iData;

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            logic [DATA_W-1:0] w_pix;
            logic [c_AW-1:0]   w_sum;
            logic [c_AW-1:0]   r_acc;

            assign w_pix = iData[c*DATA_W +: DATA_W];
            // The first pixel of a group restarts the sum, which also discards
            // any partial group cut short by a start-of-frame.
            assign w_sum = w_first ? c_AW'(w_pix) : r_acc + c_AW'(w_pix);
            assign w_avg[c*DATA_W +: DATA_W] = w_sum[X_SHIFT +: DATA_W];

            always_ff @(posedge iclk) begin
                if (irst) begin
                    r_acc <= '0;
                end else if (iDVAL && w_keep) begin
                    r_acc <= w_sum;
                end
            end
        end
    endgenerate

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_mode  <= 1'b0;
        end else if (iDVAL) begin
            r_mode <= w_mode;
            if (w_x == c_X_LAST) begin
                r_x_cnt <= '0;
                r_y_cnt <= (w_y == c_Y_LAST) ? '0 : w_y + 1'b1;
            end else begin
                r_x_cnt <= w_x + 1'b1;
                r_y_cnt <= w_y;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            oDVAL <= 1'b0;
            oEOL  <= 1'b0;
            oEOF  <= 1'b0;
            oData <= '0;
        end else begin
            oDVAL <= w_emit;
            oEOL  <= w_emit && w_eol;
            oEOF  <= w_emit && w_eof;
            if (w_emit) begin
                oData <= w_out;
            end
        end
    end

endmodule
`default_nettype wire
